// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
// Provides the digit width, the all-off anode pattern and leading-zero mask logic.
package seg_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Bit k set when digit k and every digit above it hold zero; digit 0 is never masked.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [DIGIT_W*MAX_DIGITS-1:0] val,
    input int                            num_digits
  );
    logic                  seen;
    logic [MAX_DIGITS-1:0] m;
    seen = 1'b0;
    m    = '0;
    for (int k = MAX_DIGITS - 1; k > 0; k--) begin
      if (k < num_digits) begin
        if (val[DIGIT_W*k +: DIGIT_W] != '0) seen = 1'b1;
        m[k] = ~seen;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-side bundle of the scanner: control/load inputs and per-digit drive outputs.
// The master side feeds values and observes the scan; the slave side is the scanner.
interface seg_scan_mux_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8
);

  logic                          enable;
  logic                          load;
  logic [DIGIT_W*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]         dp_in;
  logic [DIGIT_W-1:0]            nibble;
  logic [NUM_DIGITS-1:0]         an;
  logic                          dp_n;
  logic                          blank;
  logic                          frame_done;

  modport master (
    output enable, load, value, dp_in,
    input  nibble, an, dp_n, blank, frame_done
  );

  modport slave (
    input  enable, load, value, dp_in,
    output nibble, an, dp_n, blank, frame_done
  );

endinterface

// File: rtl/seg_refresh_div.sv
// Free-running refresh divider: counts 0..REFRESH_DIV-1 and flags the last count.
module seg_refresh_div
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = clog2(REFRESH_DIV);

  logic [CW-1:0] r_div_cnt;
  logic          w_last;

  assign w_last = (r_div_cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_last) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  assign o_tick = w_last;

endmodule

// File: rtl/seg_scan_mux.sv
// Common-anode multi-digit scanner feeding a nibble-to-segment decoder.
// New display words are taken only at frame boundaries so a frame is never torn.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_mux_if.slave io_scan
);

  localparam int IDX_W     = clog2(NUM_DIGITS);
  localparam int IDX_MAX_W = clog2(MAX_DIGITS);
  localparam int VAL_W     = DIGIT_W * NUM_DIGITS;
  localparam int LZ_W      = DIGIT_W * MAX_DIGITS;

  logic                  w_tick;
  logic                  w_last_digit;
  logic                  w_wrap;

  logic [IDX_W-1:0]      r_idx_p0;
  logic [VAL_W-1:0]      r_disp_p0;
  logic [NUM_DIGITS-1:0] r_disp_dp_p0;
  logic [VAL_W-1:0]      r_pend;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend_vld;

  logic [MAX_DIGITS-1:0] w_lz_full;
  logic                  w_lz_cur;
  logic                  w_vis;
  logic [NUM_DIGITS-1:0] w_sel;

  logic [NUM_DIGITS-1:0] r_an_p1;
  logic [DIGIT_W-1:0]    r_nibble_p1;
  logic                  r_dp_n_p1;
  logic                  r_blank_p1;
  logic                  r_frame_done_p1;

  seg_refresh_div #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .o_tick(w_tick)
  );

  assign w_last_digit = (r_idx_p0 == IDX_W'(NUM_DIGITS - 1));
  assign w_wrap       = w_tick && w_last_digit;

  // Stage p0: digit index and the committed display word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx_p0 <= '0;
    end else if (w_tick) begin
      r_idx_p0 <= w_last_digit ? '0 : r_idx_p0 + IDX_W'(1);
    end
  end

  // A load landing on the wrap cycle goes straight to the display and cancels any pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp_p0    <= '0;
      r_disp_dp_p0 <= '0;
      r_pend       <= '0;
      r_pend_dp    <= '0;
      r_pend_vld   <= 1'b0;
    end else if (w_wrap && io_scan.load) begin
      r_disp_p0    <= io_scan.value;
      r_disp_dp_p0 <= io_scan.dp_in;
      r_pend_vld   <= 1'b0;
    end else if (w_wrap && r_pend_vld) begin
      r_disp_p0    <= r_pend;
      r_disp_dp_p0 <= r_pend_dp;
      r_pend_vld   <= 1'b0;
    end else if (io_scan.load) begin
      r_pend       <= io_scan.value;
      r_pend_dp    <= io_scan.dp_in;
      r_pend_vld   <= 1'b1;
    end
  end

  assign w_lz_full = lz_mask(LZ_W'(r_disp_p0), NUM_DIGITS);
  assign w_lz_cur  = (LZ_BLANK != 0) && w_lz_full[IDX_MAX_W'(r_idx_p0)];
  assign w_vis     = io_scan.enable && !w_lz_cur;
  assign w_sel     = NUM_DIGITS'(1) << r_idx_p0;

  // Stage p1: registered display drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an_p1         <= AN_OFF[NUM_DIGITS-1:0];
      r_nibble_p1     <= '0;
      r_dp_n_p1       <= 1'b1;
      r_blank_p1      <= 1'b1;
      r_frame_done_p1 <= 1'b0;
    end else begin
      r_an_p1         <= w_vis ? ~w_sel : AN_OFF[NUM_DIGITS-1:0];
      r_nibble_p1     <= r_disp_p0[DIGIT_W*r_idx_p0 +: DIGIT_W];
      r_dp_n_p1       <= ~(w_vis && r_disp_dp_p0[r_idx_p0]);
      r_blank_p1      <= ~w_vis;
      r_frame_done_p1 <= w_wrap;
    end
  end

  assign io_scan.an         = r_an_p1;
  assign io_scan.nibble     = r_nibble_p1;
  assign io_scan.dp_n       = r_dp_n_p1;
  assign io_scan.blank      = r_blank_p1;
  assign io_scan.frame_done = r_frame_done_p1;

endmodule
